// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 16-input round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/mux_16to1.sv
// Sixteen-way word multiplexer; input i occupies data_in[i*WIDTH +: WIDTH].
module mux_16to1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [16*WIDTH-1:0] data_in,
  input  logic [3:0]          sel,
  output logic [WIDTH-1:0]    data_out
);

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (sel == 4'(i)) data_out = data_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/rr_pick16.sv
// Combinational rotating-priority search: first set req bit at or above ptr, wrapping 15->0.
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // 4-bit add wraps naturally from 15 back to 0
      cand = ptr + SEL_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter_16.sv
// Round-robin arbiter feeding a single-entry output register through mux_16to1.
module mux_arbiter_16
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic [SEL_W-1:0]       sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready
);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr;
  logic             win_any;
  logic [SEL_W-1:0] win_idx;
  logic [WIDTH-1:0] win_word;
  logic             capture;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr),
    .any (win_any),
    .idx (win_idx)
  );

  mux_16to1 #(.WIDTH(WIDTH)) u_mux (
    .data_in  (req_data),
    .sel      (win_idx),
    .data_out (win_word)
  );

  assign capture   = win_any && ((state == IDLE) || out_ready);
  assign out_valid = (state == FULL);

  // ack is combinational, so it is gated by rst_n to read zero while reset is held
  always_comb begin
    ack = '0;
    if (capture && rst_n) ack[win_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (capture) state_nxt = FULL;
      FULL: if (out_ready && !win_any) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sel      <= '0;
      ptr      <= '0;
    end else if (capture) begin
      out_data <= win_word;
      sel      <= win_idx;
      ptr      <= win_idx + 1'b1;
    end
  end

endmodule
